apb_mst_arb: RTL and testbench

APB_MST_ARB -- requirements
Module: apb_mst_arb

---
 rtl/apb_mst_arb.sv | 147 ++++++++++++++
 tb/tb_apb_mst_arb.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mst_arb.sv
// apb_mst_arb: two-requester APB master, round-robin arbitration,
// ACCESS-phase timeout; every output is registered.
module apb_mst_arb #(
    parameter logic [7:0] TO_MAX = 8'd255
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  cnt_q;
    logic        win_q;
    logic        last_q;
    logic        gnt;
    logic        fin_ok;
    logic        fin_to;
    logic [31:0] cap;

    // last_q resets to 1 so requester 0 wins the first tie
    always_comb begin
        gnt = 1'b0;
        if (req0 && req1) begin
            gnt = ~last_q;
        end else if (req1) begin
            gnt = 1'b1;
        end
    end

    always_comb begin
        fin_ok = (state_q == ACCESS) && pready;
        fin_to = (state_q == ACCESS) && !pready && (cnt_q == TO_MAX);
        cap    = (fin_ok && !pwrite) ? prdata : 32'd0;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req0 || req1) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (fin_ok || fin_to) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // paddr/pwdata/pwrite double as the latched payload
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= 32'd0;
            pwdata  <= 32'd0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rdata0  <= 32'd0;
            rdata1  <= 32'd0;
            busy    <= 1'b0;
            cnt_q   <= 8'd0;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            busy <= (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        win_q  <= gnt;
                        last_q <= gnt;
                        psel   <= 1'b1;
                        pwrite <= gnt ? we1 : we0;
                        paddr  <= gnt ? addr1 : addr0;
                        pwdata <= gnt ? wdata1 : wdata0;
                        cnt_q  <= 8'd0;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (fin_ok || fin_to) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        pwrite  <= 1'b0;
                        paddr   <= 32'd0;
                        pwdata  <= 32'd0;
                        if (win_q) begin
                            ack1   <= 1'b1;
                            err1   <= fin_to;
                            rdata1 <= cap;
                        end else begin
                            ack0   <= 1'b1;
                            err0   <= fin_to;
                            rdata0 <= cap;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mst_arb.sv
// tb_apb_mst_arb: directed table, corner sequences and a randomized
// run against a transaction-level reference model.
module tb_apb_mst_arb;

    localparam int TM = 255;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, busy;

    int checks = 0;
    int errors = 0;

    apb_mst_arb #(.TO_MAX(8'd255)) dut (
        .pclk(pclk), .presetn(presetn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .busy(busy)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        r0;
        logic        r1;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          waits;
        logic        ea1;
        logic        eerr;
        logic [31:0] erd;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        prdata = 0; pready = 0;
    endtask

    task automatic do_reset();
        @(negedge pclk);
        presetn = 0;
        drive_idle();
        repeat (2) @(negedge pclk);
        presetn = 1;
    endtask

    task automatic wait_ack(input bit which, output bit seen);
        seen = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge pclk);
            if (which ? ack1 : ack0) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic wait_pen(output bit seen);
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge pclk);
            if (penable) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic run_table();
        vec_t tbl[8];
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h1B00_3004, 32'h0,
                   32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 3};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h1B00_3108, 32'h0000_00A5,
                   32'h1234_5678, 3, 1'b1, 1'b0, 32'h0, 6};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h1B00_4000, 32'h0,
                   32'hCAFE_F00D, 300, 1'b0, 1'b1, 32'h0, 258};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h1B00_4004, 32'h0,
                   32'h5A5A_0001, 255, 1'b0, 1'b0, 32'h5A5A_0001, 258};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h1B00_0008, 32'h0,
                   32'h0BAD_CAFE, 254, 1'b1, 1'b0, 32'h0BAD_CAFE, 257};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h1B00_400C, 32'h7777_0000,
                   32'h9999_9999, 400, 1'b1, 1'b1, 32'h0, 258};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h1B00_0100, 32'h0,
                   32'h0101_0101, 1, 1'b0, 1'b0, 32'h0101_0101, 4};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h1B00_0200, 32'h0,
                   32'h0202_0202, 0, 1'b1, 1'b0, 32'h0202_0202, 3};
        for (int i = 0; i < 8; i++) begin
            int acc;
            bit ok;
            bit got;
            @(negedge pclk);
            req0 = tbl[i].r0; req1 = tbl[i].r1;
            we0 = tbl[i].we; we1 = tbl[i].we;
            addr0 = tbl[i].addr; addr1 = tbl[i].addr;
            wdata0 = tbl[i].wdata; wdata1 = tbl[i].wdata;
            prdata = tbl[i].rd; pready = 0;
            acc = 0; ok = 1; got = 0;
            for (int t = 1; t <= 400; t++) begin
                @(negedge pclk);
                if (ack0 || ack1) begin
                    got = 1;
                    chk("vec_lat", t, tbl[i].lat);
                    chk("vec_who", ack1, tbl[i].ea1);
                    chk("vec_both", ack0 & ack1, 0);
                    chk("vec_err", tbl[i].ea1 ? err1 : err0, tbl[i].eerr);
                    chk("vec_rdata", tbl[i].ea1 ? rdata1 : rdata0,
                        tbl[i].erd);
                    chk("vec_stable", ok, 1);
                    chk("vec_done_bus", {psel, penable, pwrite}, 0);
                    chk("vec_done_addr", paddr | pwdata, 0);
                    break;
                end
                if (psel && penable) begin
                    if (paddr !== tbl[i].addr || pwdata !== tbl[i].wdata ||
                        pwrite !== tbl[i].we)
                        ok = 0;
                    pready = (acc >= tbl[i].waits);
                    acc++;
                end else begin
                    pready = 0;
                end
            end
            if (!got) chk("vec_ack_seen", 0, 1);
            req0 = 0; req1 = 0; pready = 0;
        end
    endtask

    task automatic run_contention();
        int who[4];
        int at[4];
        int n;
        who = '{-1, -1, -1, -1};
        at = '{0, 0, 0, 0};
        n = 0;
        do_reset();
        @(negedge pclk);
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        addr0 = 32'h1B00_0010; addr1 = 32'h1B00_0020;
        pready = 1; prdata = 32'h1111_2222;
        for (int t = 1; t <= 40; t++) begin
            @(negedge pclk);
            if (psel && !penable)
                chk("cont_setup_addr", paddr,
                    (n % 2 == 0) ? addr0 : addr1);
            if (ack0 || ack1) begin
                who[n] = ack1 ? 1 : 0;
                at[n] = t;
                n++;
                if (n == 4) break;
            end
        end
        chk("cont_cnt", n, 4);
        chk("cont_first", at[0], 3);
        for (int k = 0; k < 4; k++) chk("cont_gnt", who[k], k % 2);
        for (int k = 1; k < 4; k++) chk("cont_gap", at[k] - at[k-1], 4);
        req0 = 0; req1 = 0;
    endtask

    task automatic run_reset_access();
        bit seen;
        do_reset();
        @(negedge pclk);
        req1 = 1; we1 = 0; addr1 = 32'h1B00_0B0B; pready = 0;
        wait_pen(seen);
        chk("rst_acc_seen", seen, 1);
        req0 = 1; we0 = 0; addr0 = 32'h1B00_0A0A;
        presetn = 0;
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_pen", penable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_paddr", paddr, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge pclk);
            chk("rst_noack", {ack0, ack1}, 0);
        end
        presetn = 1; pready = 1; prdata = 32'h0000_ABCD;
        @(negedge pclk);
        chk("rst_resume", psel, 1);
        chk("rst_win0", paddr, 32'h1B00_0A0A);
        wait_ack(0, seen);
        chk("rst_ack0", seen, 1);
        chk("rst_rd0", rdata0, 32'h0000_ABCD);
        req0 = 0;
        wait_ack(1, seen);
        chk("rst_ack1", seen, 1);
        req1 = 0;
        @(negedge pclk);
        req1 = 1; pready = 0;
        wait_pen(seen);
        chk("rst2_acc_seen", seen, 1);
        presetn = 0;
        #1;
        chk("rst2_busy", busy, 0);
        @(negedge pclk);
        presetn = 1;
        @(negedge pclk);
        chk("rst2_resume", psel, 1);
        chk("rst2_win1", paddr, 32'h1B00_0B0B);
        pready = 1;
        wait_ack(1, seen);
        chk("rst2_ack1", seen, 1);
        req1 = 0;
    endtask

    task automatic run_random(input int ncyc);
        int          m_start, m_n, m_w, d, r;
        bit          m_act, m_to, m_win, m_last, m_we, p0, p1;
        logic [31:0] m_addr, m_wdata, m_rd;
        logic [31:0] e_rd[2];
        bit          e_err[2];
        bit          x_sel, x_en, x_wr, x_busy, x_a0, x_a1;
        logic [31:0] x_addr, x_wd;
        m_act = 0; m_last = 1; p0 = 0; p1 = 0;
        m_start = 0; m_n = 0; m_w = 0; m_to = 0; m_win = 0; m_we = 0;
        m_addr = 0; m_wdata = 0; m_rd = 0;
        e_rd = '{32'd0, 32'd0};
        e_err = '{1'b0, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            @(negedge pclk);
            d = m_act ? c - m_start : -1;
            x_sel = 0; x_en = 0; x_wr = 0; x_busy = 0;
            x_a0 = 0; x_a1 = 0; x_addr = 0; x_wd = 0;
            if (m_act && d <= m_n + 1) begin
                x_busy = 1;
                if (d <= m_n) begin
                    x_sel = 1; x_en = (d >= 1); x_wr = m_we;
                    x_addr = m_addr; x_wd = m_wdata;
                end else begin
                    x_a0 = !m_win; x_a1 = m_win;
                    e_err[m_win] = m_to;
                    e_rd[m_win] = m_rd;
                end
            end
            chk("rnd_psel", psel, x_sel);
            chk("rnd_pen", penable, x_en);
            chk("rnd_pwrite", pwrite, x_wr);
            chk("rnd_paddr", paddr, x_addr);
            chk("rnd_pwdata", pwdata, x_wd);
            chk("rnd_busy", busy, x_busy);
            chk("rnd_ack0", ack0, x_a0);
            chk("rnd_ack1", ack1, x_a1);
            chk("rnd_err0", err0, e_err[0]);
            chk("rnd_err1", err1, e_err[1]);
            chk("rnd_rdata0", rdata0, e_rd[0]);
            chk("rnd_rdata1", rdata1, e_rd[1]);
            prdata = $urandom;
            if (m_act && d >= 1 && d <= m_n) begin
                pready = (d - 1 >= m_w);
                if (d - 1 == m_w) m_rd = m_we ? 32'd0 : prdata;
            end else begin
                pready = 1'($urandom_range(0, 1));
            end
            if (x_a0) begin
                p0 = 0;
            end else if (!p0) begin
                we0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom;
                p0 = ($urandom_range(0, 2) == 0);
            end
            if (x_a1) begin
                p1 = 0;
            end else if (!p1) begin
                we1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom;
                p1 = ($urandom_range(0, 2) == 0);
            end
            req0 = p0; req1 = p1;
            if ((!m_act || d >= m_n + 2) && (p0 || p1)) begin
                m_win = (p0 && p1) ? !m_last : p1;
                m_last = m_win;
                m_act = 1;
                m_start = c + 1;
                m_we = m_win ? we1 : we0;
                m_addr = m_win ? addr1 : addr0;
                m_wdata = m_win ? wdata1 : wdata0;
                r = $urandom_range(0, 39);
                m_w = (r < 36) ? r % 4 : (r < 38) ? TM : TM + 1 + r % 3;
                m_to = (m_w > TM);
                m_n = m_to ? TM + 1 : m_w + 1;
                m_rd = 0;
            end
        end
        req0 = 0; req1 = 0;
    endtask

    initial begin
        drive_idle();
        presetn = 0;
        repeat (2) @(negedge pclk);
        chk("reset_psel", psel, 0);
        chk("reset_pen", penable, 0);
        chk("reset_pwrite", pwrite, 0);
        chk("reset_paddr", paddr, 0);
        chk("reset_pwdata", pwdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ack", {ack0, ack1}, 0);
        chk("reset_err", {err0, err1}, 0);
        chk("reset_rdata", rdata0 | rdata1, 0);
        presetn = 1;
        run_table();
        run_contention();
        run_reset_access();
        do_reset();
        run_random(4000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
